// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the RISC-V core front end.
// Fetch FSM states, default widths and opcode encodings.
package riscv_core_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with sequential step and aligned redirect load.
// Flags a misaligned redirect target one cycle after it is taken.
module fetch_pc_reg
  import riscv_core_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc,
  output logic            misalign_err
);

  logic [XLEN-1:0] target_aligned;

  assign target_aligned = {redirect_target[XLEN-1:2], 2'b00};

  // A redirect always wins over the sequential step.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && (redirect_target[1:0] != 2'b00);
      if (redirect_valid) begin
        pc <= target_aligned;
      end else if (inc) begin
        pc <= pc + XLEN'(PC_STEP);
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues imem requests, holds the fetched instruction
// for decode, and squashes responses made stale by a redirect.
module instr_fetch_unit
  import riscv_core_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            stall,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
  output logic            misalign_err
);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [XLEN-1:0] pc;
  logic            hs;
  logic            load_inst;
  logic            consume;

  assign imem_req_valid = (state == REQ) && !reset;
  assign imem_req_addr  = pc;
  assign hs             = imem_req_valid && imem_req_ready;
  assign opcode         = inst[6:0];

  assign load_inst = (state == WAIT) && imem_resp_valid
                     && !redirect_valid;
  assign consume   = (state == HOLD)
                     && (redirect_valid || !stall);

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk             (clk),
    .reset           (reset),
    .inc             (load_inst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc              (pc),
    .misalign_err    (misalign_err)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      REQ: begin
        if (hs) begin
          state_nxt = redirect_valid ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          state_nxt = redirect_valid ? REQ : HOLD;
        end else if (redirect_valid) begin
          state_nxt = DROP;
        end
      end
      // The stale response retires the request whatever else happens.
      DROP: begin
        if (imem_resp_valid) begin
          state_nxt = REQ;
        end
      end
      HOLD: begin
        if (consume) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= REQ;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      state <= state_nxt;
      if (load_inst) begin
        inst       <= imem_resp_data;
        inst_pc    <= pc;
        inst_valid <= 1'b1;
      end else if (consume) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit with a
// request-level reference model and a variable-latency imem.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic        misalign_err;

  int compared = 0;
  int mismatched = 0;

  // reference model: outstanding / discard / holding flags
  logic        m_out, m_disc, m_hold, m_mis;
  logic [31:0] m_pc, m_inst, m_ipc;

  // imem model
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_data;
  int          lat_lo, lat_hi;
  logic        use_fixed;
  logic [31:0] fixed_data;
  logic        inject;

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .opcode          (opcode),
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    logic rv;
    rv = !reset && !m_out && !m_hold;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, rv});
    if (rv) chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_hold});
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_ipc);
    chk("opcode", {25'b0, opcode}, {25'b0, m_inst[6:0]});
    chk("misalign", {31'b0, misalign_err}, {31'b0, m_mis});
  endtask

  task automatic cycle();
    logic mresp, resp, hs;
    logic [31:0] data, npc;
    mresp = mem_busy && (mem_cnt == 0);
    resp  = mresp || (inject && !mem_busy);
    data  = mresp ? mem_data : $urandom;
    imem_resp_valid = resp;
    imem_resp_data  = data;
    hs = !m_out && !m_hold && imem_req_ready;
    @(posedge clk);
    #1;
    if (reset) begin
      m_out = 0; m_disc = 0; m_hold = 0; m_mis = 0;
      m_pc = 32'h0; m_inst = 0; m_ipc = 0;
      mem_busy = 0;
    end else begin
      npc = redirect_valid ? (redirect_target & ~32'h3) : m_pc;
      if (m_hold) begin
        if (redirect_valid || !stall) m_hold = 0;
      end else if (!m_out) begin
        if (hs) begin
          m_out = 1;
          m_disc = redirect_valid;
        end
      end else if (resp) begin
        m_out = 0;
        if (!m_disc && !redirect_valid) begin
          m_hold = 1;
          m_inst = data;
          m_ipc = m_pc;
          npc = m_pc + 32'd4;
        end
        m_disc = 0;
      end else if (redirect_valid) begin
        m_disc = 1;
      end
      m_pc  = npc;
      m_mis = redirect_valid && (redirect_target[1:0] != 2'b00);
      if (mresp) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (hs) begin
        mem_busy = 1;
        mem_cnt  = $urandom_range(lat_hi, lat_lo) - 1;
        mem_data = use_fixed ? fixed_data : $urandom;
      end
    end
    inject = 0;
    check_model();
  endtask

  initial begin
    logic [31:0] held_inst, held_pc;
    reset = 1; imem_req_ready = 1; redirect_valid = 0;
    redirect_target = 0; stall = 0; inject = 0;
    imem_resp_valid = 0; imem_resp_data = 0;
    m_out = 0; m_disc = 0; m_hold = 0; m_mis = 0;
    m_pc = 0; m_inst = 0; m_ipc = 0;
    mem_busy = 0; mem_cnt = 0; mem_data = 0;
    lat_lo = 1; lat_hi = 1;
    use_fixed = 1; fixed_data = 32'h00208033;

    cycle();
    cycle();
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    reset = 0;
    #1;
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    cycle();
    cycle();
    chk("t1_valid", {31'b0, inst_valid}, 32'h1);
    chk("t1_opcode", {25'b0, opcode}, 32'h33);
    chk("t1_inst_pc", inst_pc, 32'h0);
    held_inst = inst;
    held_pc   = inst_pc;

    stall = 1;
    repeat (3) begin
      cycle();
      chk("stall_inst", inst, held_inst);
      chk("stall_pc", inst_pc, held_pc);
      chk("stall_req", {31'b0, imem_req_valid}, 32'h0);
    end
    stall = 0;
    cycle();
    chk("rel_valid", {31'b0, inst_valid}, 32'h0);
    chk("rel_addr", imem_req_addr, 32'h4);

    lat_lo = 3; lat_hi = 3; fixed_data = 32'h00000013;
    cycle();
    redirect_valid = 1; redirect_target = 32'h40;
    cycle();
    redirect_valid = 0;
    for (int i = 0; i < 10 && !imem_req_valid; i++) cycle();
    chk("drop_req", {31'b0, imem_req_valid}, 32'h1);
    chk("drop_valid", {31'b0, inst_valid}, 32'h0);
    chk("drop_addr", imem_req_addr, 32'h40);

    lat_lo = 1; lat_hi = 1;
    cycle();
    redirect_valid = 1; redirect_target = 32'h40;
    cycle();
    redirect_valid = 0;
    chk("same_req", {31'b0, imem_req_valid}, 32'h1);
    chk("same_addr", imem_req_addr, 32'h40);
    chk("same_valid", {31'b0, inst_valid}, 32'h0);

    imem_req_ready = 0;
    redirect_valid = 1; redirect_target = 32'h42;
    cycle();
    redirect_valid = 0;
    chk("mis_hi", {31'b0, misalign_err}, 32'h1);
    chk("mis_addr", imem_req_addr, 32'h40);
    cycle();
    chk("mis_lo", {31'b0, misalign_err}, 32'h0);

    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 0; imem_req_ready = 1;
    cycle();
    cycle();
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_addr", imem_req_addr, 32'h0);
    cycle();
    reset = 1;
    cycle();
    chk("mid_rst_req", {31'b0, imem_req_valid}, 32'h0);
    chk("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
    reset = 0;
    #1;
    chk("post_rst_req", {31'b0, imem_req_valid}, 32'h1);
    chk("post_rst_addr", imem_req_addr, 32'h0);

    use_fixed = 0; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(199, 0) == 0);
      imem_req_ready = ($urandom_range(3, 0) != 0);
      stall          = $urandom_range(1, 0) == 1;
      redirect_valid = ($urandom_range(7, 0) == 0);
      redirect_target = $urandom;
      if ($urandom_range(3, 0) == 0)
        redirect_target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      inject = ($urandom_range(15, 0) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
